// File: rtl/typing_pkg.sv
// Shared types and helpers for the typing matcher: FSM state encoding,
// default letter width and MSB-first letter extraction from a packed word.
package typing_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    ACTIVE    = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int unsigned LETTER_W_DEFAULT = 5;

  // Upper bound on MAX_LEN*LETTER_W accepted by letter_at
  localparam int unsigned WORD_MAX_W = 256;

  // Returns letter idx of a max_len-letter word whose first letter sits in
  // the MSBs, zero-extended to 32 bits so callers of any LETTER_W can use it.
  function automatic logic [31:0] letter_at(input logic [WORD_MAX_W-1:0] word,
                                            input int unsigned idx,
                                            input int unsigned letter_w,
                                            input int unsigned max_len);
    logic [WORD_MAX_W-1:0] shifted;
    shifted = word >> ((max_len - 1 - idx) * letter_w);
    return shifted[31:0] & ((32'd1 << letter_w) - 32'd1);
  endfunction

endpackage

// File: rtl/word_timer.sv
// Per-word countdown: reloads to TIME_LIMIT, counts ticks down, and flags
// the decrement that lands on zero.
module word_timer #(
  parameter  int unsigned TIME_LIMIT = 30,
  localparam int unsigned TIME_W     = $clog2(TIME_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              dec,
  output logic [TIME_W-1:0] count,
  output logic              expire
);

  // Load has priority over decrement; the count never wraps below zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= TIME_W'(TIME_LIMIT);
    end else if (dec && (count != '0)) begin
      count <= count - TIME_W'(1);
    end
  end

  assign expire = dec && (count == TIME_W'(1));

endmodule

// File: rtl/typing_matcher.sv
// Typing game core: accepts a word, checks released keys letter by letter,
// counts misses and completed words, and ends the game on too many misses
// or when the per-word timer runs out.
module typing_matcher
  import typing_pkg::*;
#(
  parameter  int unsigned LETTER_W   = LETTER_W_DEFAULT,
  parameter  int unsigned MAX_LEN    = 8,
  parameter  int unsigned MAX_MISSES = 3,
  parameter  int unsigned TIME_LIMIT = 30,
  parameter  int unsigned SCORE_W    = 8,
  localparam int unsigned WORD_W     = MAX_LEN * LETTER_W,
  localparam int unsigned LEN_W      = $clog2(MAX_LEN + 1),
  localparam int unsigned IDX_W      = $clog2(MAX_LEN),
  localparam int unsigned MISS_W     = $clog2(MAX_MISSES + 1),
  localparam int unsigned TIME_W     = $clog2(TIME_LIMIT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                wordValid,
  input  logic [WORD_W-1:0]   wordIn,
  input  logic [LEN_W-1:0]    wordLen,
  input  logic                keyValid,
  input  logic [LETTER_W-1:0] keyCode,
  input  logic                tick,
  output logic                wordReq,
  output logic                wordComplete,
  output logic                mistake,
  output logic                gameOver,
  output logic [IDX_W-1:0]    letterIdx,
  output logic [MISS_W-1:0]   missCount,
  output logic [SCORE_W-1:0]  score,
  output logic [TIME_W-1:0]   timeLeft
);

  state_t               state, state_next;
  logic [WORD_W-1:0]    word_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     len_clamped;
  logic [WORD_MAX_W-1:0] word_ext;
  logic [31:0]          expected;
  logic                 key_match;
  logic                 last_letter;
  logic                 in_active;
  logic                 completing;
  logic                 tmr_load;
  logic                 tmr_dec;
  logic                 tmr_expire;
  logic                 latch;
  logic                 complete_next;
  logic                 mistake_next;
  logic [IDX_W-1:0]     idx_next;
  logic [MISS_W-1:0]    miss_next;
  logic [SCORE_W-1:0]   score_next;

  // Widen the latched word to the fixed width the extraction helper takes
  always_comb begin
    word_ext = '0;
    word_ext[WORD_W-1:0] = word_q;
  end

  assign expected    = letter_at(word_ext, 32'(letterIdx), LETTER_W, MAX_LEN);
  assign key_match   = (expected == 32'(keyCode));
  assign last_letter = ((32'(letterIdx) + 32'd1) >= 32'(len_q));
  assign in_active   = (state == ACTIVE);
  assign completing  = in_active && keyValid && key_match && last_letter;

  // The key is judged before the tick, so a completing key suppresses the
  // same-cycle decrement and with it any expiry.
  assign tmr_dec  = in_active && tick && !completing;
  assign tmr_load = (state == WAIT_WORD) && wordValid;

  word_timer #(
    .TIME_LIMIT(TIME_LIMIT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .count (timeLeft),
    .expire(tmr_expire)
  );

  // Clamp the presented length into 1..MAX_LEN
  always_comb begin
    len_clamped = wordLen;
    if (wordLen == '0) begin
      len_clamped = LEN_W'(1);
    end else if (32'(wordLen) > MAX_LEN) begin
      len_clamped = LEN_W'(MAX_LEN);
    end
  end

  // Next-state and next-output decisions for the game FSM
  always_comb begin
    state_next    = state;
    latch         = 1'b0;
    complete_next = 1'b0;
    mistake_next  = 1'b0;
    idx_next      = letterIdx;
    miss_next     = missCount;
    score_next    = score;
    unique case (state)
      IDLE, GAME_OVER: begin
        if (start) begin
          state_next = WAIT_WORD;
          score_next = '0;
          miss_next  = '0;
        end
      end
      WAIT_WORD: begin
        if (wordValid) begin
          latch      = 1'b1;
          idx_next   = '0;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (keyValid) begin
          if (key_match) begin
            if (last_letter) begin
              complete_next = 1'b1;
              if (score != '1) score_next = score + SCORE_W'(1);
              state_next = WAIT_WORD;
            end else begin
              idx_next = letterIdx + IDX_W'(1);
            end
          end else begin
            mistake_next = 1'b1;
            miss_next    = missCount + MISS_W'(1);
            if (32'(miss_next) == MAX_MISSES) state_next = GAME_OVER;
          end
        end
        if (tmr_expire) state_next = GAME_OVER;
      end
      default: state_next = IDLE;
    endcase
  end

  // Register state, latched word and all counter/pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      word_q       <= '0;
      len_q        <= '0;
      letterIdx    <= '0;
      missCount    <= '0;
      score        <= '0;
      wordComplete <= 1'b0;
      mistake      <= 1'b0;
    end else begin
      state        <= state_next;
      letterIdx    <= idx_next;
      missCount    <= miss_next;
      score        <= score_next;
      wordComplete <= complete_next;
      mistake      <= mistake_next;
      if (latch) begin
        word_q <= wordIn;
        len_q  <= len_clamped;
      end
    end
  end

  assign wordReq  = (state == WAIT_WORD);
  assign gameOver = (state == GAME_OVER);

endmodule

// File: tb/tb_typing_matcher.sv
// Directed bench for typing_matcher: default-parameter instance for the
// matching/miss/reset flows, TIME_LIMIT=2 instance for timer expiry.
module tb_typing_matcher;

  localparam logic [4:0] KA = 5'd1;
  localparam logic [4:0] KB = 5'd2;
  localparam logic [4:0] KC = 5'd3;
  localparam logic [4:0] KD = 5'd4;
  localparam logic [4:0] KX = 5'd24;
  localparam logic [39:0] W_ABCD = {5'd1, 5'd2, 5'd3, 5'd4, 20'd0};
  localparam logic [39:0] W_8    = {5'd1, 5'd2, 5'd3, 5'd4, 5'd1, 5'd2, 5'd3, 5'd4};
  localparam logic [39:0] W_A    = {5'd1, 35'd0};
  localparam logic [39:0] W_AB   = {5'd1, 5'd2, 30'd0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance
  logic        start, word_valid, key_valid, tick;
  logic [39:0] word_in;
  logic [3:0]  word_len;
  logic [4:0]  key_code;
  logic        word_req, word_complete, mistake, game_over;
  logic [2:0]  letter_idx;
  logic [1:0]  miss_count;
  logic [7:0]  score;
  logic [4:0]  time_left;

  // short-timer instance
  logic        start2, word_valid2, key_valid2, tick2;
  logic [39:0] word_in2;
  logic [3:0]  word_len2;
  logic [4:0]  key_code2;
  logic        word_req2, word_complete2, mistake2, game_over2;
  logic [2:0]  letter_idx2;
  logic [1:0]  miss_count2;
  logic [7:0]  score2;
  logic [1:0]  time_left2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typing_matcher dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wordValid(word_valid),
    .wordIn(word_in), .wordLen(word_len), .keyValid(key_valid),
    .keyCode(key_code), .tick(tick), .wordReq(word_req),
    .wordComplete(word_complete), .mistake(mistake), .gameOver(game_over),
    .letterIdx(letter_idx), .missCount(miss_count), .score(score),
    .timeLeft(time_left)
  );

  typing_matcher #(.TIME_LIMIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .wordValid(word_valid2),
    .wordIn(word_in2), .wordLen(word_len2), .keyValid(key_valid2),
    .keyCode(key_code2), .tick(tick2), .wordReq(word_req2),
    .wordComplete(word_complete2), .mistake(mistake2), .gameOver(game_over2),
    .letterIdx(letter_idx2), .missCount(miss_count2), .score(score2),
    .timeLeft(time_left2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic present(input logic [39:0] w, input logic [3:0] len);
    word_valid = 1'b1; word_in = w; word_len = len;
    cyc();
    word_valid = 1'b0;
  endtask

  task automatic press(input logic [4:0] code);
    key_valid = 1'b1; key_code = code;
    cyc();
    key_valid = 1'b0;
  endtask

  task automatic present2(input logic [39:0] w, input logic [3:0] len);
    word_valid2 = 1'b1; word_in2 = w; word_len2 = len;
    cyc();
    word_valid2 = 1'b0;
  endtask

  task automatic step2(input logic kv, input logic [4:0] code, input logic tk);
    key_valid2 = kv; key_code2 = code; tick2 = tk;
    cyc();
    key_valid2 = 1'b0; tick2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; word_valid = 0; key_valid = 0; tick = 0;
    word_in = '0; word_len = '0; key_code = '0;
    start2 = 0; word_valid2 = 0; key_valid2 = 0; tick2 = 0;
    word_in2 = '0; word_len2 = '0; key_code2 = '0;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_wordreq",   word_req, 0);
    chk("rst_complete",  word_complete, 0);
    chk("rst_mistake",   mistake, 0);
    chk("rst_gameover",  game_over, 0);
    chk("rst_idx",       letter_idx, 0);
    chk("rst_miss",      miss_count, 0);
    chk("rst_score",     score, 0);
    chk("rst_timeleft",  time_left, 0);
    rst_n = 1'b1;
    cyc();

    // first game, clean word
    do_start();
    chk("start_wordreq", word_req, 1);
    chk("start_score",   score, 0);
    press(KA);
    chk("waitkey_mistake", mistake, 0);
    chk("waitkey_idx",     letter_idx, 0);
    present(W_ABCD, 4'd4);
    chk("latch_wordreq",  word_req, 0);
    chk("latch_timeleft", time_left, 30);
    chk("latch_idx",      letter_idx, 0);
    press(KA); chk("idx_a", letter_idx, 1);
    press(KB); chk("idx_b", letter_idx, 2);
    press(KC); chk("idx_c", letter_idx, 3);
    chk("no_early_complete", word_complete, 0);
    press(KD);
    chk("complete_pulse",  word_complete, 1);
    chk("complete_score",  score, 1);
    chk("complete_wordreq", word_req, 1);
    cyc();
    chk("complete_onecycle", word_complete, 0);

    // one miss mid-word
    present(W_ABCD, 4'd4);
    press(KA); chk("miss_pre_idx", letter_idx, 1);
    press(KX);
    chk("miss_pulse", mistake, 1);
    chk("miss_count", miss_count, 1);
    chk("miss_idx_held", letter_idx, 1);
    cyc();
    chk("miss_onecycle", mistake, 0);
    press(KB); press(KC); press(KD);
    chk("miss_word_complete", word_complete, 1);
    chk("miss_word_score", score, 2);

    // start ignored while waiting for a word
    do_start();
    chk("start_ignored_score", score, 2);
    chk("start_ignored_miss",  miss_count, 1);

    // length 0 behaves as 1
    present(W_A, 4'd0);
    press(KA);
    chk("len0_complete", word_complete, 1);
    chk("len0_score", score, 3);

    // length above MAX_LEN clamps to 8
    present(W_8, 4'd15);
    press(KA); press(KB); press(KC); press(KD);
    press(KA); press(KB); press(KC);
    chk("len15_idx7", letter_idx, 7);
    chk("len15_not_done", word_complete, 0);
    press(KD);
    chk("len15_complete", word_complete, 1);
    chk("len15_score", score, 4);

    // remaining misses end the game; score held
    present(W_ABCD, 4'd4);
    press(KX); chk("go_miss2", miss_count, 2);
    chk("go_not_yet", game_over, 0);
    press(KX);
    chk("go_miss3", miss_count, 3);
    chk("go_flag", game_over, 1);
    chk("go_score_held", score, 4);
    press(KA);
    chk("go_key_no_mistake", mistake, 0);
    chk("go_key_miss", miss_count, 3);
    chk("go_key_score", score, 4);

    // restart from GAME_OVER, three consecutive misses
    do_start();
    chk("restart_gameover", game_over, 0);
    chk("restart_score", score, 0);
    chk("restart_miss", miss_count, 0);
    chk("restart_wordreq", word_req, 1);
    present(W_ABCD, 4'd4);
    press(KX); chk("x1_mistake", mistake, 1); chk("x1_miss", miss_count, 1);
    press(KX); chk("x2_mistake", mistake, 1); chk("x2_miss", miss_count, 2);
    chk("x2_gameover", game_over, 0);
    press(KX); chk("x3_mistake", mistake, 1); chk("x3_miss", miss_count, 3);
    chk("x3_gameover", game_over, 1);
    press(KB);
    chk("x4_mistake", mistake, 0);
    chk("x4_miss", miss_count, 3);
    chk("x4_idx", letter_idx, 0);

    // asynchronous reset mid-word
    do_start();
    present(W_ABCD, 4'd4);
    press(KA); press(KB); press(KC); press(KD);
    chk("pre_reset_score", score, 1);
    present(W_ABCD, 4'd4);
    press(KA); press(KB);
    chk("pre_reset_idx", letter_idx, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_idx", letter_idx, 0);
    chk("areset_score", score, 0);
    chk("areset_timeleft", time_left, 0);
    chk("areset_wordreq", word_req, 0);
    chk("areset_gameover", game_over, 0);
    chk("areset_miss", miss_count, 0);
    rst_n = 1'b1;
    cyc();
    do_start();
    chk("post_reset_wordreq", word_req, 1);
    chk("post_reset_score", score, 0);

    // timer expiry with TIME_LIMIT=2
    start2 = 1'b1; cyc(); start2 = 1'b0;
    present2(W_ABCD, 4'd4);
    chk("t_load", time_left2, 2);
    step2(1'b0, KA, 1'b1);
    chk("t_tick1", time_left2, 1);
    chk("t_tick1_go", game_over2, 0);
    step2(1'b0, KA, 1'b1);
    chk("t_tick2", time_left2, 0);
    chk("t_tick2_go", game_over2, 1);

    // completing key coincident with the expiring tick
    start2 = 1'b1; cyc(); start2 = 1'b0;
    present2(W_AB, 4'd2);
    chk("tc_load", time_left2, 2);
    step2(1'b1, KA, 1'b0);
    step2(1'b0, KA, 1'b1);
    chk("tc_tick1", time_left2, 1);
    step2(1'b1, KB, 1'b1);
    chk("tc_complete", word_complete2, 1);
    chk("tc_no_gameover", game_over2, 0);
    chk("tc_score", score2, 1);
    chk("tc_wordreq", word_req2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
